// File: rtl/reg_writeback_queue.sv
// Write-back queue in front of the register file write port: merges ALU and
// load results in program order, drains one per free cycle, and forwards pending values.
module reg_writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ALU_VALID,
  input  logic [ADDR_WIDTH-1:0]   ALU_ADDR,
  input  logic [DATA_WIDTH-1:0]   ALU_DATA,
  output logic                    ALU_READY,
  input  logic                    MEM_VALID,
  input  logic [ADDR_WIDTH-1:0]   MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]   MEM_DATA,
  output logic                    MEM_READY,
  input  logic                    RF_BUSY,
  output logic                    WRITE,
  output logic [ADDR_WIDTH-1:0]   ADDR_W,
  output logic [DATA_WIDTH-1:0]   DATA_W,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R1,
  input  logic [ADDR_WIDTH-1:0]   ADDR_R2,
  output logic                    HIT_R1,
  output logic                    HIT_R2,
  output logic [DATA_WIDTH-1:0]   FWD_R1,
  output logic [DATA_WIDTH-1:0]   FWD_R2,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] q_addr [DEPTH];
  logic [DATA_WIDTH-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      alu_slot;
  logic [CNT_W-1:0]      free;
  logic [CNT_W-1:0]      n_push;
  logic                  mem_acc;
  logic                  alu_acc;
  logic                  mem_push;
  logic                  alu_push;
  logic                  drain;

  // Space is judged from the registered count only; a same-cycle drain frees nothing.
  assign free      = CNT_W'(DEPTH) - COUNT;
  assign MEM_READY = !RST && (free >= CNT_W'(1));
  assign ALU_READY = !RST && (MEM_VALID ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));

  assign mem_acc  = MEM_VALID && MEM_READY;
  assign alu_acc  = ALU_VALID && ALU_READY;
  assign mem_push = mem_acc && (MEM_ADDR != '0);
  assign alu_push = alu_acc && (ALU_ADDR != '0);
  assign drain    = (COUNT != '0) && !RF_BUSY;
  assign alu_slot = tail + PTR_W'(mem_push);
  assign n_push   = CNT_W'(mem_push) + CNT_W'(alu_push);

  always_ff @(posedge CLK) begin
    if (RST) begin
      head   <= '0;
      tail   <= '0;
      COUNT  <= '0;
      WRITE  <= 1'b0;
      ADDR_W <= '0;
      DATA_W <= '0;
    end else begin
      // Load result is older than a same-cycle ALU result, so it takes the first slot.
      if (mem_push) begin
        q_addr[tail] <= MEM_ADDR;
        q_data[tail] <= MEM_DATA;
      end
      if (alu_push) begin
        q_addr[alu_slot] <= ALU_ADDR;
        q_data[alu_slot] <= ALU_DATA;
      end
      tail  <= tail + PTR_W'(n_push);
      WRITE <= drain;
      if (drain) begin
        ADDR_W <= q_addr[head];
        DATA_W <= q_data[head];
        head   <= head + PTR_W'(1);
      end
      COUNT <= COUNT + n_push - CNT_W'(drain);
    end
  end

  // Oldest candidate first so the youngest match is the last one kept.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] r;
    logic [PTR_W-1:0]    idx;
    r = '0;
    if (WRITE && (ADDR_W == a)) r = {1'b1, DATA_W};
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < COUNT) && (q_addr[idx] == a)) r = {1'b1, q_data[idx]};
    end
    if (RST || (a == '0)) r = '0;
    return r;
  endfunction

  always_comb begin
    {HIT_R1, FWD_R1} = lookup(ADDR_R1);
    {HIT_R2, FWD_R2} = lookup(ADDR_R2);
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios then random traffic, all
// compared each cycle against a queue-based model of the write-back buffer.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ALU_VALID, MEM_VALID, RF_BUSY;
  logic [AW-1:0] ALU_ADDR, MEM_ADDR, ADDR_R1, ADDR_R2;
  logic [DW-1:0] ALU_DATA, MEM_DATA;
  logic          ALU_READY, MEM_READY, WRITE, HIT_R1, HIT_R2;
  logic [AW-1:0] ADDR_W;
  logic [DW-1:0] DATA_W, FWD_R1, FWD_R2;
  logic [2:0]    COUNT;

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .RF_BUSY(RF_BUSY), .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .HIT_R1(HIT_R1), .HIT_R2(HIT_R2),
    .FWD_R1(FWD_R1), .FWD_R2(FWD_R2), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          m_write;
  logic [AW-1:0] m_addr_w;
  logic [DW-1:0] m_data_w;
  bit            m_alu_acc, m_mem_acc;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void mlook(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (RST || a == '0) return;
    if (m_write && m_addr_w == a) begin h = 1'b1; d = m_data_w; end
    foreach (q[i]) if (q[i].a == a) begin h = 1'b1; d = q[i].d; end
  endfunction

  // Called at posedge+1: check everything, advance the model, cross the next edge.
  task automatic tick();
    int            free;
    logic          h;
    logic [DW-1:0] d;
    ent_t          e;
    #1;
    free = DEPTH - q.size();
    check("count",     64'(COUNT),     64'(q.size()));
    check("write",     64'(WRITE),     64'(m_write));
    check("addr_w",    64'(ADDR_W),    64'(m_addr_w));
    check("data_w",    64'(DATA_W),    64'(m_data_w));
    check("mem_ready", 64'(MEM_READY), 64'(!RST && free >= 1));
    check("alu_ready", 64'(ALU_READY), 64'(!RST && (MEM_VALID ? free >= 2 : free >= 1)));
    mlook(ADDR_R1, h, d);
    check("hit_r1", 64'(HIT_R1), 64'(h));
    check("fwd_r1", 64'(FWD_R1), 64'(d));
    mlook(ADDR_R2, h, d);
    check("hit_r2", 64'(HIT_R2), 64'(h));
    check("fwd_r2", 64'(FWD_R2), 64'(d));
    m_mem_acc = !RST && MEM_VALID && free >= 1;
    m_alu_acc = !RST && ALU_VALID && (MEM_VALID ? free >= 2 : free >= 1);
    if (RST) begin
      q.delete();
      m_write = 1'b0; m_addr_w = '0; m_data_w = '0;
    end else begin
      if (q.size() > 0 && !RF_BUSY) begin
        e = q.pop_front();
        m_write = 1'b1; m_addr_w = e.a; m_data_w = e.d;
      end else begin
        m_write = 1'b0;
      end
      if (m_mem_acc && MEM_ADDR != '0) q.push_back({MEM_ADDR, MEM_DATA});
      if (m_alu_acc && ALU_ADDR != '0) q.push_back({ALU_ADDR, ALU_DATA});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ALU_VALID = 1'b0; MEM_VALID = 1'b0; RF_BUSY = 1'b0;
  endtask

  initial begin
    RST = 1'b1; idle();
    ALU_ADDR = '0; ALU_DATA = '0; MEM_ADDR = '0; MEM_DATA = '0;
    ADDR_R1 = '0; ADDR_R2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    q.delete(); m_write = 1'b0; m_addr_w = '0; m_data_w = '0;

    // reset held, then released
    tick();
    RST = 1'b0;
    tick();

    // single ALU write to R3
    ALU_VALID = 1'b1; ALU_ADDR = 5'd3; ALU_DATA = 32'h0000_0003; ADDR_R1 = 5'd3;
    tick();
    ALU_VALID = 1'b0;
    tick();
    check("single_write", 64'(WRITE), 64'd1);
    check("single_addr",  64'(ADDR_W), 64'd3);
    check("single_data",  64'(DATA_W), 64'd3);
    tick();

    // dual offer to R5: MEM older, ALU younger
    MEM_VALID = 1'b1; MEM_ADDR = 5'd5; MEM_DATA = 32'hAAAA_0005;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd5; ALU_DATA = 32'hBBBB_0005; ADDR_R1 = 5'd5;
    tick();
    idle();
    check("dual_hit", 64'(HIT_R1), 64'd1);
    check("dual_fwd", 64'(FWD_R1), 64'hBBBB_0005);
    tick();
    check("dual_first",  64'(DATA_W), 64'hAAAA_0005);
    check("dual_fwd2",   64'(FWD_R1), 64'hBBBB_0005);
    tick();
    check("dual_second", 64'(DATA_W), 64'hBBBB_0005);
    tick();
    tick();

    // fill under RF_BUSY, hold a fifth offer, then release
    RF_BUSY = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      ALU_VALID = 1'b1; ALU_ADDR = AW'(r); ALU_DATA = 32'h1000_0000 + DW'(r);
      tick();
    end
    ALU_ADDR = 5'd9; ALU_DATA = 32'h1000_0009;
    check("full_count",     64'(COUNT),     64'd4);
    check("full_alu_ready", 64'(ALU_READY), 64'd0);
    check("full_mem_ready", 64'(MEM_READY), 64'd0);
    tick();
    RF_BUSY = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (m_alu_acc) ALU_VALID = 1'b0;
    end
    idle();

    // R0 discard
    ALU_VALID = 1'b1; ALU_ADDR = 5'd0; ALU_DATA = 32'hFFFF_FFFF; ADDR_R1 = 5'd0;
    tick();
    ALU_VALID = 1'b0;
    check("r0_count", 64'(COUNT),  64'd0);
    check("r0_hit",   64'(HIT_R1), 64'd0);
    tick();
    check("r0_write", 64'(WRITE),  64'd0);

    // reset while draining
    RF_BUSY = 1'b1;
    MEM_VALID = 1'b1; MEM_ADDR = 5'd7; MEM_DATA = 32'h7777_0001;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd8; ALU_DATA = 32'h8888_0001;
    tick();
    MEM_VALID = 1'b0; ALU_ADDR = 5'd7; ALU_DATA = 32'h7777_0002;
    tick();
    ALU_VALID = 1'b0; RF_BUSY = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_write", 64'(WRITE), 64'd0);
    check("mid_rst_count", 64'(COUNT), 64'd0);
    repeat (3) tick();

    // random traffic; producers hold their offer until accepted
    for (int c = 0; c < 400; c++) begin
      RST     = ($urandom_range(0, 59) == 0);
      RF_BUSY = ($urandom_range(0, 2) == 0);
      ADDR_R1 = AW'($urandom_range(0, 7));
      ADDR_R2 = AW'($urandom_range(0, 7));
      if (!MEM_VALID || m_mem_acc) begin
        MEM_VALID = $urandom_range(0, 1) == 1;
        MEM_ADDR  = AW'($urandom_range(0, 7));
        MEM_DATA  = $urandom;
      end
      if (!ALU_VALID || m_alu_acc) begin
        ALU_VALID = $urandom_range(0, 1) == 1;
        ALU_ADDR  = AW'($urandom_range(0, 7));
        ALU_DATA  = $urandom;
      end
      tick();
    end
    RST = 1'b0; idle();
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
